// File: rtl/hfg_stage_classifier_if.sv
// hfg_stage_classifier_if: feature-beat, stage-control and result signals of the cascade stage evaluator.
interface hfg_stage_classifier_if #(
  parameter int FEAT_W = 32,
  parameter int VAL_W  = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 12
);
  logic                     iStart;
  logic [CNT_W-1:0]         iNum_Features;
  logic signed [ACC_W-1:0]  iStage_Threshold;
  logic                     iValid;
  logic signed [FEAT_W-1:0] iFeature;
  logic signed [FEAT_W-1:0] iWeak_Threshold;
  logic signed [VAL_W-1:0]  iLeft_Val;
  logic signed [VAL_W-1:0]  iRight_Val;
  logic                     oBusy;
  logic [CNT_W-1:0]         oFeature_Idx;
  logic                     oDone;
  logic                     oPass;
  logic signed [ACC_W-1:0]  oStage_Sum;
  modport master (
    output iStart, iNum_Features, iStage_Threshold, iValid, iFeature, iWeak_Threshold, iLeft_Val, iRight_Val,
    input  oBusy, oFeature_Idx, oDone, oPass, oStage_Sum
  );
  modport slave (
    input  iStart, iNum_Features, iStage_Threshold, iValid, iFeature, iWeak_Threshold, iLeft_Val, iRight_Val,
    output oBusy, oFeature_Idx, oDone, oPass, oStage_Sum
  );
endinterface

// File: rtl/hfg_stage_classifier.sv
// hfg_stage_classifier: accumulates weak-classifier leaf values over one cascade stage and reports pass/fail.
module hfg_stage_classifier #(
  parameter int FEAT_W = 32,
  parameter int VAL_W  = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 12
) (
  input logic iClk,
  input logic iReset_n,
  hfg_stage_classifier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DECIDE} state_t;
  localparam logic signed [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};
  state_t                  r_state, w_next;
  logic [CNT_W-1:0]        r_n, r_idx;
  logic signed [ACC_W-1:0] r_thr, r_acc, r_sum, w_acc_sat;
  logic signed [ACC_W:0]   w_wide;
  logic signed [VAL_W-1:0] r_leaf;
  logic                    r_leaf_v, r_done, r_pass;
  logic                    w_start, w_accept, w_last;
  // A new stage may not start in the oDone cycle, so results are never overwritten while presented.
  assign w_start  = r_state == IDLE && !r_done && bus.iStart;
  assign w_accept = r_state == ACCUM && bus.iValid;
  assign w_last   = w_accept && r_idx + CNT_W'(1) == r_n;
  assign w_wide   = {r_acc[ACC_W-1], r_acc} + {{(ACC_W+1-VAL_W){r_leaf[VAL_W-1]}}, r_leaf};
  assign w_acc_sat = w_wide[ACC_W] != w_wide[ACC_W-1] ? (w_wide[ACC_W] ? MIN : MAX) : w_wide[ACC_W-1:0];
  always_ff @(posedge iClk)
    r_state <= !iReset_n ? IDLE : w_next;
  // DRAIN lasts exactly one cycle: the only beat still in flight is added on the DRAIN->DECIDE edge.
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (w_start ? (bus.iNum_Features != '0 ? ACCUM : DRAIN) : IDLE) :
             r_state == ACCUM ? (w_last ? DRAIN : ACCUM) :
             r_state == DRAIN ? DECIDE : IDLE;
  end
  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      r_n      <= '0;
      r_thr    <= '0;
      r_idx    <= '0;
      r_leaf   <= '0;
      r_leaf_v <= 1'b0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_sum    <= '0;
    end else begin
      r_leaf_v <= w_accept;
      r_done   <= r_state == DECIDE;
      r_idx    <= w_start ? '0 : w_accept ? r_idx + CNT_W'(1) : r_idx;
      r_acc    <= w_start ? '0 : r_leaf_v ? w_acc_sat : r_acc;
      if (w_start) begin
        r_n   <= bus.iNum_Features;
        r_thr <= bus.iStage_Threshold;
      end
      if (w_accept)
        r_leaf <= bus.iFeature < bus.iWeak_Threshold ? bus.iLeft_Val : bus.iRight_Val;
      if (r_state == DECIDE) begin
        r_sum  <= r_acc;
        r_pass <= r_acc >= r_thr;
      end
    end
  end
  assign bus.oBusy        = r_state != IDLE || r_done;
  assign bus.oFeature_Idx = r_idx;
  assign bus.oDone        = r_done;
  assign bus.oPass        = r_pass;
  assign bus.oStage_Sum   = r_sum;
endmodule
